// File: rtl/ppu_spr_seq_if.sv
// Sprite sequencer bus: line setup inputs, secondary-OAM read port, pattern
// fetch handshake and the load bus towards the eight sprite units.
interface ppu_spr_seq_if;
  logic        i_start;
  logic        i_render_en;
  logic        i_pix_win;
  logic [7:0]  i_scanline;
  logic [3:0]  i_spr_cnt;
  logic        i_spr0_hit;
  logic [4:0]  o_soam_addr;
  logic [7:0]  i_soam_data;
  logic        o_fetch_req;
  logic [7:0]  o_fetch_tile;
  logic [2:0]  o_fetch_row;
  logic        i_fetch_ack;
  logic [15:0] i_fetch_data;
  logic [7:0]  o_slot_sel;
  logic [7:0]  o_xcnt;
  logic        o_xcnt_wr;
  logic [7:0]  o_attr;
  logic        o_attr_we;
  logic [15:0] o_patt;
  logic        o_patt_we;
  logic        o_primary;
  logic        o_run;
  logic        o_busy;

  modport master (
    input  i_start, i_render_en, i_pix_win, i_scanline, i_spr_cnt, i_spr0_hit,
           i_soam_data, i_fetch_ack, i_fetch_data,
    output o_soam_addr, o_fetch_req, o_fetch_tile, o_fetch_row, o_slot_sel,
           o_xcnt, o_xcnt_wr, o_attr, o_attr_we, o_patt, o_patt_we,
           o_primary, o_run, o_busy
  );

  modport slave (
    output i_start, i_render_en, i_pix_win, i_scanline, i_spr_cnt, i_spr0_hit,
           i_soam_data, i_fetch_ack, i_fetch_data,
    input  o_soam_addr, o_fetch_req, o_fetch_tile, o_fetch_row, o_slot_sel,
           o_xcnt, o_xcnt_wr, o_attr, o_attr_we, o_patt, o_patt_we,
           o_primary, o_run, o_busy
  );
endinterface

// File: rtl/ppu_spr_seq.sv
// Sprite fetch sequencer: walks the eight secondary-OAM slots during the
// sprite-fetch window, fetches each pattern row and loads the sprite units.
//
// state   | meaning
// IDLE    | waiting for start pulse with rendering enabled
// RD_Y    | read secondary-OAM byte 0 (Y), 2 cycles
// RD_T    | read byte 1 (tile), 2 cycles
// RD_A    | read byte 2 (attributes), 2 cycles
// RD_X    | read byte 3 (X), 2 cycles
// FETCH   | pattern request held until ack
// LOAD_XA | write X counter and attributes to selected unit
// LOAD_P  | write pattern to selected unit
// NEXT    | advance slot, finish after slot 7
module ppu_spr_seq (
  input logic           i_clk,
  input logic           i_rstn,
  ppu_spr_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD_Y, RD_T, RD_A, RD_X, FETCH, LOAD_XA, LOAD_P, NEXT
  } state_t;

  state_t      state, state_nx;
  logic        ph;
  logic [2:0]  s;
  logic [7:0]  y_r, tile_r, attr_r, x_r;
  logic [15:0] patt_r;

  logic [3:0]  eff_cnt;
  logic        cur_empty, nxt_empty, is_rd;
  logic [2:0]  row_raw, row;

  assign eff_cnt   = (bus.i_spr_cnt > 4'd8) ? 4'd8 : bus.i_spr_cnt;
  assign cur_empty = ({1'b0, s} >= eff_cnt);
  assign nxt_empty = (({1'b0, s} + 4'd1) >= eff_cnt);
  assign is_rd     = (state == RD_Y) || (state == RD_T) ||
                     (state == RD_A) || (state == RD_X);
  assign row_raw   = 3'(bus.i_scanline - y_r);
  assign row       = attr_r[7] ? ~row_raw : row_raw;

  assign bus.o_busy     = (state != IDLE);
  assign bus.o_slot_sel = bus.o_busy ? (8'd1 << s) : 8'h00;
  assign bus.o_run      = bus.i_pix_win & bus.i_render_en & ~bus.o_busy;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_start && bus.i_render_en)
                 state_nx = (eff_cnt == 4'd0) ? LOAD_XA : RD_Y;
      RD_Y:    if (ph) state_nx = RD_T;
      RD_T:    if (ph) state_nx = RD_A;
      RD_A:    if (ph) state_nx = RD_X;
      RD_X:    if (ph) state_nx = FETCH;
      FETCH:   if (bus.i_fetch_ack) state_nx = LOAD_XA;
      LOAD_XA: state_nx = LOAD_P;
      LOAD_P:  state_nx = NEXT;
      NEXT:    if (s == 3'd7) state_nx = IDLE;
               else           state_nx = nxt_empty ? LOAD_XA : RD_Y;
      default: state_nx = IDLE;
    endcase
    // losing render enable abandons the line; units keep what they have
    if (!bus.i_render_en && state != IDLE) state_nx = IDLE;
  end

  always_comb begin
    bus.o_soam_addr  = 5'd0;
    bus.o_fetch_req  = 1'b0;
    bus.o_fetch_tile = 8'h00;
    bus.o_fetch_row  = 3'd0;
    bus.o_xcnt       = 8'h00;
    bus.o_xcnt_wr    = 1'b0;
    bus.o_attr       = 8'h00;
    bus.o_attr_we    = 1'b0;
    bus.o_patt       = 16'h0000;
    bus.o_patt_we    = 1'b0;
    bus.o_primary    = 1'b0;
    case (state)
      RD_Y:  bus.o_soam_addr = {s, 2'd0};
      RD_T:  bus.o_soam_addr = {s, 2'd1};
      RD_A:  bus.o_soam_addr = {s, 2'd2};
      RD_X:  bus.o_soam_addr = {s, 2'd3};
      FETCH: begin
        bus.o_fetch_req  = 1'b1;
        bus.o_fetch_tile = tile_r;
        bus.o_fetch_row  = row;
      end
      LOAD_XA: begin
        bus.o_xcnt_wr = 1'b1;
        bus.o_attr_we = 1'b1;
        bus.o_xcnt    = cur_empty ? 8'hFF : x_r;
        bus.o_attr    = cur_empty ? 8'h00 : attr_r;
        bus.o_primary = (s == 3'd0) & bus.i_spr0_hit;
      end
      LOAD_P: begin
        bus.o_patt_we = 1'b1;
        bus.o_patt    = cur_empty ? 16'h0000 : patt_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ph     <= 1'b0;
      s      <= 3'd0;
      y_r    <= 8'h00;
      tile_r <= 8'h00;
      attr_r <= 8'h00;
      x_r    <= 8'h00;
      patt_r <= 16'h0000;
    end else begin
      // second cycle of each read: data for the address is now valid
      ph <= is_rd & ~ph & (state_nx == state);
      if (state == IDLE)      s <= 3'd0;
      else if (state == NEXT) s <= s + 3'd1;
      if (ph) begin
        case (state)
          RD_Y:    y_r    <= bus.i_soam_data;
          RD_T:    tile_r <= bus.i_soam_data;
          RD_A:    attr_r <= bus.i_soam_data;
          RD_X:    x_r    <= bus.i_soam_data;
          default: ;
        endcase
      end
      if (state == FETCH && bus.i_fetch_ack) patt_r <= bus.i_fetch_data;
    end
  end

endmodule

// File: tb/tb_ppu_spr_seq.sv
// Self-checking bench for ppu_spr_seq: secondary-OAM and pattern-fetch models,
// load monitor, and a slot-list reference model of the eight unit loads.
module tb_ppu_spr_seq;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ppu_spr_seq_if bus();
  ppu_spr_seq dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct { logic [7:0] sel; logic [7:0] x; logic [7:0] attr; logic prim; } xa_t;
  typedef struct { logic [7:0] sel; logic [15:0] patt; } p_t;
  typedef struct { logic [7:0] scan; logic [7:0] y; logic [7:0] attr; logic [2:0] row; } vec_t;

  logic [7:0] soam_mem [32];
  logic [4:0] addr_prev = 5'd0;
  int         lat = 0;
  int         wait_cnt = 0;
  logic [7:0] hold_tile;
  logic [2:0] hold_row;
  xa_t        xa_q[$];
  p_t         p_q[$];
  logic [2:0] row_q[$];
  int         req_cycles = 0;
  int         addr_nz = 0;
  int         busy_run_bad = 0;
  logic       prev_attr_we = 1'b0;
  logic [7:0] prev_sel = 8'h00;

  function automatic logic [15:0] patt_fn(logic [7:0] t, logic [2:0] r);
    return {~t, t + {r, 5'b0}};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // environment: OAM read with one-cycle latency, fetch responder, load monitor
  always @(negedge clk) begin
    bus.i_soam_data = soam_mem[addr_prev];
    addr_prev = bus.o_soam_addr;
    if (bus.o_soam_addr != 5'd0) addr_nz++;
    if (bus.o_fetch_req) begin
      req_cycles++;
      if (wait_cnt == 0) begin
        hold_tile = bus.o_fetch_tile;
        hold_row  = bus.o_fetch_row;
      end else begin
        chk("fetch_tile_stable", bus.o_fetch_tile, hold_tile);
        chk("fetch_row_stable", bus.o_fetch_row, hold_row);
      end
      if (wait_cnt >= lat) begin
        bus.i_fetch_ack  = 1'b1;
        bus.i_fetch_data = patt_fn(bus.o_fetch_tile, bus.o_fetch_row);
        row_q.push_back(bus.o_fetch_row);
        wait_cnt = 0;
      end else begin
        bus.i_fetch_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.i_fetch_ack = 1'b0;
      wait_cnt = 0;
    end
    if (bus.o_attr_we || bus.o_xcnt_wr)
      chk("xcnt_wr_with_attr_we", bus.o_xcnt_wr, bus.o_attr_we);
    if (bus.o_attr_we)
      xa_q.push_back('{bus.o_slot_sel, bus.o_xcnt, bus.o_attr, bus.o_primary});
    if (bus.o_patt_we) begin
      p_q.push_back('{bus.o_slot_sel, bus.o_patt});
      chk("attr_precedes_patt", prev_attr_we, 1);
      chk("patt_same_slot", bus.o_slot_sel, prev_sel);
    end
    if (bus.o_busy && bus.i_pix_win && bus.o_run) busy_run_bad++;
    prev_attr_we = bus.o_attr_we;
    prev_sel     = bus.o_slot_sel;
  end

  task automatic set_slot(int k, logic [7:0] y, logic [7:0] t, logic [7:0] a, logic [7:0] x);
    soam_mem[4*k]   = y;
    soam_mem[4*k+1] = t;
    soam_mem[4*k+2] = a;
    soam_mem[4*k+3] = x;
  endtask

  task automatic clear_logs();
    xa_q.delete();
    p_q.delete();
    row_q.delete();
    req_cycles   = 0;
    addr_nz      = 0;
    busy_run_bad = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic run_seq(int lat_in, int glitch_at);
    int n;
    lat = lat_in;
    clear_logs();
    pulse_start();
    chk("busy_after_start", bus.o_busy, 1);
    n = 0;
    while (bus.o_busy && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == glitch_at)     bus.i_start = 1'b1;
      if (n == glitch_at + 1) bus.i_start = 1'b0;
    end
    chk("seq_done_in_budget", bus.o_busy, 0);
  endtask

  // reference: what each of the eight units must receive for this line
  task automatic check_loads(string tag, int cnt, logic hit, logic [7:0] scan);
    int eff, r;
    logic [7:0] y, t, a, x;
    logic [15:0] ep;
    logic [24:0] exa;
    eff = (cnt > 8) ? 8 : cnt;
    chk({tag, "_xa_count"}, xa_q.size(), 8);
    chk({tag, "_p_count"}, p_q.size(), 8);
    if (xa_q.size() == 8 && p_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        if (k < eff) begin
          y = soam_mem[4*k]; t = soam_mem[4*k+1];
          a = soam_mem[4*k+2]; x = soam_mem[4*k+3];
          r = (int'(scan) - int'(y)) & 7;
          if (a[7]) r = 7 - r;
          ep = patt_fn(t, 3'(r));
        end else begin
          x = 8'hFF; a = 8'h00; ep = 16'h0000;
        end
        exa = {8'(1 << k), x, a, (k == 0) ? hit : 1'b0};
        chk($sformatf("%s_xa_slot%0d", tag, k),
            {7'd0, xa_q[k].sel, xa_q[k].x, xa_q[k].attr, xa_q[k].prim}, {7'd0, exa});
        chk($sformatf("%s_patt_slot%0d", tag, k),
            {p_q[k].sel, p_q[k].patt}, {8'(1 << k), ep});
      end
    end
  endtask

  task automatic wait_sel(logic [7:0] sel, logic need_req, string nm);
    int n = 0;
    while (!(bus.o_slot_sel == sel && (!need_req || bus.o_fetch_req)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.o_slot_sel, sel);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl [5];

  initial begin
    logic [7:0] scan;
    int cnt;
    logic hit;

    tbl[0] = '{8'd20,  8'd16,  8'h80, 3'd3};
    tbl[1] = '{8'd20,  8'd16,  8'h00, 3'd4};
    tbl[2] = '{8'd2,   8'd250, 8'h00, 3'd0};
    tbl[3] = '{8'd2,   8'd250, 8'h80, 3'd7};
    tbl[4] = '{8'd100, 8'd97,  8'h00, 3'd3};

    bus.i_start = 1'b0; bus.i_render_en = 1'b1; bus.i_pix_win = 1'b0;
    bus.i_scanline = 8'd0; bus.i_spr_cnt = 4'd0; bus.i_spr0_hit = 1'b0;
    bus.i_soam_data = 8'h00; bus.i_fetch_ack = 1'b0; bus.i_fetch_data = 16'h0;
    for (int i = 0; i < 32; i++) soam_mem[i] = 8'h00;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_outputs",
        {bus.o_slot_sel, bus.o_soam_addr, bus.o_fetch_req, bus.o_xcnt_wr,
         bus.o_attr_we, bus.o_patt_we, bus.o_primary}, 0);
    chk("reset_data", {bus.o_xcnt, bus.o_attr, bus.o_patt}, 0);
    rstn = 1'b1;

    bus.i_pix_win = 1'b1;
    #1 chk("run_idle", bus.o_run, 1);
    bus.i_render_en = 1'b0;
    #1 chk("run_no_render", bus.o_run, 0);
    pulse_start();
    chk("start_ignored_no_render", bus.o_busy, 0);
    bus.i_render_en = 1'b1;
    bus.i_pix_win = 1'b0;

    // row / flip / wrap table, one sprite per line
    for (int i = 0; i < 5; i++) begin
      set_slot(0, tbl[i].y, 8'h42 + 8'(i), tbl[i].attr, 8'h10 + 8'(i));
      bus.i_spr_cnt = 4'd1; bus.i_scanline = tbl[i].scan; bus.i_spr0_hit = 1'b0;
      run_seq(0, -10);
      chk($sformatf("tbl%0d_fetches", i), row_q.size(), 1);
      if (row_q.size() >= 1) chk($sformatf("tbl%0d_row", i), row_q[0], tbl[i].row);
      check_loads($sformatf("tbl%0d", i), 1, 1'b0, tbl[i].scan);
    end

    // full line, sprite 0 primary, pixels requested while busy, stray start
    for (int i = 0; i < 32; i++) soam_mem[i] = 8'($urandom);
    scan = 8'($urandom);
    bus.i_spr_cnt = 4'd8; bus.i_scanline = scan; bus.i_spr0_hit = 1'b1; bus.i_pix_win = 1'b1;
    run_seq(0, 30);
    check_loads("full", 8, 1'b1, scan);
    chk("full_fetches", req_cycles, 8);
    chk("run_low_while_busy", busy_run_bad, 0);
    bus.i_pix_win = 1'b0; bus.i_spr0_hit = 1'b0;

    // empty line
    bus.i_spr_cnt = 4'd0;
    run_seq(0, -10);
    check_loads("empty", 0, 1'b0, scan);
    chk("empty_no_fetch", req_cycles, 0);
    chk("empty_no_soam_read", addr_nz, 0);

    // backpressure
    bus.i_spr_cnt = 4'd8;
    run_seq(5, -10);
    check_loads("backpressure", 8, 1'b0, scan);
    chk("backpressure_req_held", req_cycles, 48);

    // abort during slot 3 fetch
    lat = 2;
    clear_logs();
    pulse_start();
    wait_sel(8'h08, 1'b1, "abort_reach_slot3");
    bus.i_render_en = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_req", bus.o_fetch_req, 0);
    chk("abort_sel", bus.o_slot_sel, 0);
    chk("abort_loaded_slots", xa_q.size(), 3);
    bus.i_render_en = 1'b1;
    repeat (2) @(negedge clk);

    // reset in the middle of slot 5
    lat = 0;
    clear_logs();
    pulse_start();
    wait_sel(8'h20, 1'b0, "reset_reach_slot5");
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_outputs",
        {bus.o_busy, bus.o_slot_sel, bus.o_soam_addr, bus.o_fetch_req, bus.o_xcnt_wr,
         bus.o_attr_we, bus.o_patt_we, bus.o_primary, bus.o_run}, 0);
    chk("midreset_data",
        {bus.o_xcnt, bus.o_attr, bus.o_fetch_tile, bus.o_fetch_row, 5'd0}, 0);
    chk("midreset_patt", bus.o_patt, 0);
    rstn = 1'b1;
    @(negedge clk);

    // randomized lines against the reference model
    for (int it = 0; it < 25; it++) begin
      cnt = int'($urandom_range(0, 15));
      scan = 8'($urandom);
      for (int i = 0; i < 32; i++) soam_mem[i] = 8'($urandom);
      hit = (cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_spr_cnt = 4'(cnt); bus.i_scanline = scan; bus.i_spr0_hit = hit;
      bus.i_pix_win = 1'($urandom_range(0, 1));
      run_seq(int'($urandom_range(0, 3)), -10);
      check_loads($sformatf("rnd%0d", it), cnt, hit, scan);
      chk($sformatf("rnd%0d_fetches", it), req_cycles, ((cnt > 8) ? 8 : cnt) * (lat + 1));
      chk($sformatf("rnd%0d_run_busy", it), busy_run_bad, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_spr_seq.md
PPU_SPR_SEQ -- requirements
Module: ppu_spr_seq

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port i_rstn, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port i_start, input, 1, one-cycle pulse at start of sprite-fetch window (dot 257).
REQ-004 SHALL have port i_render_en, input, 1, sprite rendering enable.
REQ-005 SHALL have port i_pix_win, input, 1, high on visible pixel dots.
REQ-006 SHALL have port i_scanline, input, 8, line being prepared.
REQ-007 SHALL have port i_spr_cnt, input, 4, valid secondary-OAM entries, 0..8.
REQ-008 SHALL have port i_spr0_hit, input, 1, secondary entry 0 is OAM sprite 0.
REQ-009 SHALL have port o_soam_addr, output, 5, secondary-OAM byte address.
REQ-010 SHALL have port i_soam_data, input, 8, secondary-OAM read data, valid the cycle after address.
REQ-011 SHALL have port o_fetch_req, output, 1, pattern fetch request.
REQ-012 SHALL have port o_fetch_tile, output, 8, tile index.
REQ-013 SHALL have port o_fetch_row, output, 3, row within tile.
REQ-014 SHALL have port i_fetch_ack, input, 1, fetch complete.
REQ-015 SHALL have port i_fetch_data, input, 16, pattern {high plane, low plane}, valid with ack.
REQ-016 SHALL have port o_slot_sel, output, 8, one-hot target sprite unit.
REQ-017 SHALL have ports o_xcnt (8), o_xcnt_wr (1), o_attr (8), o_attr_we (1), o_patt (16), o_patt_we (1), o_primary (1), all outputs, to the selected unit.
REQ-018 SHALL have port o_run, output, 1, shift enable broadcast to all units.
REQ-019 SHALL have port o_busy, output, 1, sequence in progress.

Function
REQ-020 SHALL implement states IDLE, RD_Y, RD_T, RD_A, RD_X, FETCH, LOAD_XA, LOAD_P, NEXT.
REQ-021 IDLE -> RD_Y on i_start & i_render_en; slot counter s cleared to 0; i_start otherwise ignored, including while busy.
REQ-022 RD_Y/RD_T/RD_A/RD_X SHALL drive o_soam_addr = {s[2:0],2'd0..3} and capture i_soam_data one cycle later; each state lasts 2 cycles.
REQ-023 Row SHALL be (i_scanline - Y)[2:0], 8-bit wrap-around subtraction; inverted (7 - row) when attr[7] set.
REQ-024 FETCH SHALL hold o_fetch_req high with stable tile/row until i_fetch_ack; o_fetch_req drops the cycle after ack; data captured on ack.
REQ-025 LOAD_XA SHALL pulse o_xcnt_wr and o_attr_we together for one cycle; LOAD_P SHALL pulse o_patt_we the next cycle (attribute strictly precedes pattern).
REQ-026 o_primary SHALL equal i_spr0_hit when s==0, else 0, during LOAD_XA.
REQ-027 Slots with s >= i_spr_cnt SHALL skip RD_* and FETCH, load o_xcnt=8'hFF, o_attr=8'h00, o_patt=16'h0000.
REQ-028 NEXT SHALL increment s; after s==7 return to IDLE, else RD_Y (or LOAD_XA for empty slot).
REQ-029 o_slot_sel SHALL be one-hot of s while busy, 8'h00 in IDLE; strobes only in LOAD states.
REQ-030 o_run SHALL equal i_pix_win & i_render_en & ~o_busy, combinational.
REQ-031 i_render_en falling mid-sequence SHALL abort to IDLE next cycle, dropping o_fetch_req; loaded slots keep contents.
REQ-032 i_spr_cnt > 8 SHALL be treated as 8.

Reset
REQ-033 On i_clk with i_rstn low: state IDLE, s=0, all strobes, o_fetch_req, o_busy, o_slot_sel, o_soam_addr, captured registers zero.
REQ-034 Reset mid-sequence SHALL take precedence over all other events.

Verification
REQ-035 Full load: i_spr_cnt=8, zero-latency ack -> 8 LOAD_XA/LOAD_P pairs, o_slot_sel 01..80 in order, attr_we one cycle before patt_we.
REQ-036 Empty: i_spr_cnt=0 -> 8 loads with xcnt=FF, patt=0000, no fetch_req, no soam reads.
REQ-037 Flip: scanline=20, Y=16, attr=80 -> o_fetch_row=3; attr=00 -> row 4; Y=250, scanline=2 -> row 0 wrap.
REQ-038 Backpressure: ack delayed 5 cycles -> tile/row stable, req held, sequence stalls, then resumes.
REQ-039 Abort/reset: render_en low during slot 3 FETCH -> IDLE next cycle, busy=0, req=0; rstn low mid-slot 5 -> all outputs 0.
REQ-040 Primary: i_spr0_hit=1 -> o_primary=1 only on slot 0 load; o_run=0 while busy despite i_pix_win=1.
